// File: rtl/x_300_mod_997_loader.sv
// x_300_mod_997_loader: frames 30 ten-bit beats into a 300-bit operand,
// reduces it mod 997 and hands the residue out over valid/ready.
//
// Ports (loader):
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high
//   in_data   : 10-bit operand beat, beat 0 is the least significant
//   in_valid  : in_data valid
//   in_last   : final beat of an operand
//   in_ready  : a beat is accepted when in_valid && in_ready
//   out_r     : X mod 997 (0..996)
//   out_valid : out_r valid, held until out_ready
//   out_ready : consumer takes out_r when out_valid && out_ready
//   err       : one-cycle pulse on a framing error
//
// Ports (core x_300_mod_997):
//   i_x : 300-bit operand
//   o_r : i_x mod 997, combinational

module x_300_mod_997 (
  input  logic [299:0] i_x,
  output logic [9:0]   o_r
);

  // Horner over 10-bit digits from the top.
  // 1024 == 27 (mod 997), so r*1024 + d folds
  // to r*27 + d (<= 27915), then one more
  // fold of the upper bits by 27 (<= 1752)
  // and a single conditional subtract.
  function automatic logic [9:0] step(
    input logic [9:0] r,
    input logic [9:0] d
  );
    logic [14:0] t;
    logic [10:0] u;
    t = 15'(r) * 15'd27 + 15'(d);
    u = 11'(t[14:10]) * 11'd27
      + 11'(t[9:0]);
    if (u >= 11'd997) u = u - 11'd997;
    return u[9:0];
  endfunction

  logic [9:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 29; i >= 0; i--) begin
      w_acc = step(w_acc, i_x[i*10 +: 10]);
    end
  end

  assign o_r = w_acc;

endmodule

module x_300_mod_997_loader #(
  parameter int BEAT_W  = 10,
  parameter int N_BEATS = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [9:0]        out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  localparam int XW = BEAT_W * N_BEATS;
  localparam logic [4:0] LAST_CNT =
    5'(N_BEATS - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state;
  logic [4:0]      r_cnt;
  logic [4:0]      w_cnt;
  logic [XW-1:0]   r_shift;
  logic [XW-1:0]   w_shift;
  logic [9:0]      r_out;
  logic [9:0]      w_out;
  logic            r_valid;
  logic            w_valid;
  logic            r_err;
  logic            w_err;
  logic [9:0]      w_core;

  x_300_mod_997 u_core (
    .i_x (r_shift),
    .o_r (w_core)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_shift <= w_shift;
      r_out   <= w_out;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_out   = r_out;
    w_valid = r_valid;
    w_err   = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (in_valid) begin
          // New beats enter at the top so
          // beat 0 ends up least significant.
          w_shift = {in_data,
                     r_shift[XW-1:BEAT_W]};
          if (r_cnt == LAST_CNT) begin
            w_cnt = '0;
            if (in_last) w_state = S_CALC;
            else         w_err   = 1'b1;
          end else if (in_last) begin
            w_cnt = '0;
            w_err = 1'b1;
          end else begin
            w_cnt = r_cnt + 5'd1;
          end
        end
      end
      S_CALC: begin
        w_out   = w_core;
        w_valid = 1'b1;
        w_state = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_valid = 1'b0;
          w_cnt   = '0;
          w_state = S_LOAD;
        end
      end
      default: begin
        w_state = S_LOAD;
      end
    endcase
  end

  assign in_ready  = (r_state == S_LOAD);
  assign out_r     = r_out;
  assign out_valid = r_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_x_300_mod_997_loader.sv
// tb_x_300_mod_997_loader: directed and random
// frames checked against X % 997 arithmetic.

module tb_x_300_mod_997_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [9:0] out_r;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q[$];

  x_300_mod_997_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_r     (out_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ref_mod(
    input logic [299:0] x
  );
    logic [299:0] m;
    m = x % 300'd997;
    return m[9:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(
    input logic [9:0] d,
    input logic       l
  );
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL beat_accept: ready=%b want 1",
               in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(
    input logic [299:0] x
  );
    for (int i = 0; i < 30; i++)
      send_beat(x[i*10 +: 10], i == 29);
  endtask

  task automatic collect(
    output logic       ve,
    output logic       vl,
    output logic [9:0] r
  );
    ve = out_valid;
    tick();
    vl = out_valid;
    r  = out_r;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b want 0",
               out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got %b want 1",
               in_ready);
    end
    total++;
    if (out_r !== 10'd0) begin
      bad++;
      $display("FAIL rst_out: got %0d want 0",
               out_r);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err: got %b want 0", err);
    end
  endtask

  task automatic test_directed();
    logic [299:0] v[7];
    logic         ve, vl;
    logic [9:0]   r, e;
    v[0] = 300'd997;
    v[1] = 300'd996;
    v[2] = 300'd1 << 10;
    v[3] = 300'd1 << 20;
    v[4] = 300'd1 << 290;
    v[5] = '1;
    v[6] = 300'd1 << 280;
    for (int k = 0; k < 7; k++) begin
      e = ref_mod(v[k]);
      send_frame(v[k]);
      collect(ve, vl, r);
      total++;
      if (ve !== 1'b0 || vl !== 1'b1) begin
        bad++;
        $display("FAIL dir_lat[%0d]: v=%b%b want 01",
                 k, ve, vl);
      end
      total++;
      if (r !== e) begin
        bad++;
        $display("FAIL dir_val[%0d]: got %0d want %0d",
                 k, r, e);
      end
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir_done[%0d]: v=%b rdy=%b",
                 k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_short_frame();
    logic       ve, vl;
    logic [9:0] r;
    for (int i = 0; i < 6; i++)
      send_beat(10'($urandom_range(0, 1023)),
                i == 5);
    total++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL short_err: err=%b rdy=%b want 11",
               err, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL short_after: err=%b v=%b",
                 err, out_valid);
      end
    end
    send_frame(300'd1 << 10);
    collect(ve, vl, r);
    total++;
    if (vl !== 1'b1 || r !== 10'd27) begin
      bad++;
      $display("FAIL short_next: v=%b got %0d want 27",
               vl, r);
    end
  endtask

  task automatic test_no_last();
    logic       ve, vl;
    logic [9:0] r;
    for (int i = 0; i < 30; i++)
      send_beat(10'd5, 1'b0);
    total++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL nolast_err: err=%b rdy=%b want 11",
               err, in_ready);
    end
    tick();
    total++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL nolast_pulse: err=%b v=%b",
               err, out_valid);
    end
    send_frame(300'd1 << 20);
    collect(ve, vl, r);
    total++;
    if (vl !== 1'b1 || r !== 10'd729) begin
      bad++;
      $display("FAIL nolast_next: v=%b got %0d want 729",
               vl, r);
    end
  endtask

  task automatic test_hold();
    logic [299:0] x;
    logic [9:0]   e;
    for (int i = 0; i < 10; i++)
      x[i*30 +: 30] = 30'($urandom);
    e = ref_mod(x);
    send_frame(x);
    tick();
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_r !== e ||
          in_ready !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: v=%b r=%0d rdy=%b err=%b want 1 %0d 0 0",
                 i, out_valid, out_r, in_ready, err, e);
      end
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: rdy=%b v=%b want 10",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic       ve, vl;
    logic [9:0] r;
    for (int i = 0; i < 12; i++)
      send_beat(10'h3FF, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_load: rdy=%b v=%b want 10",
               in_ready, out_valid);
    end
    send_frame(300'd997);
    collect(ve, vl, r);
    total++;
    if (vl !== 1'b1 || r !== 10'd0) begin
      bad++;
      $display("FAIL rst_load_next: v=%b got %0d want 0",
               vl, r);
    end
    send_frame(300'd996);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_r !== 10'd0) begin
      bad++;
      $display("FAIL rst_hold: rdy=%b v=%b r=%0d want 1 0 0",
               in_ready, out_valid, out_r);
    end
    send_frame(300'd997);
    collect(ve, vl, r);
    total++;
    if (vl !== 1'b1 || r !== 10'd0) begin
      bad++;
      $display("FAIL rst_hold_next: v=%b got %0d want 0",
               vl, r);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    fork
      begin : producer
        logic [299:0] x;
        for (int f = 0; f < 1000; f++) begin
          for (int i = 0; i < 30; i++)
            x[i*10 +: 10] = (f % 50 == 0) ?
              10'h3FF : 10'($urandom_range(0, 1023));
          exp_q.push_back(ref_mod(x));
          for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0;
              in_data  = 10'($urandom);
              in_last  = 1'($urandom);
              tick();
            end
            send_beat(x[i*10 +: 10], i == 29);
          end
        end
      end
      begin : consumer
        int got = 0;
        int cyc = 0;
        logic [9:0] e;
        while (got < 1000 && cyc < 80000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ?
              exp_q.pop_front() : 10'h3FF;
            total++;
            if (out_r !== e) begin
              bad++;
              $display("FAIL rand[%0d]: got %0d want %0d",
                       got, out_r, e);
            end
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (got != 1000) begin
          bad++;
          $display("FAIL rand_count: got %0d want 1000",
                   got);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_directed();
    test_short_frame();
    test_no_last();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
